// File: rtl/instr_mem_pkg.sv
// Shared types and defaults for the instruction memory / program loader slice.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          DEF_WORD_BYTES  = 4;
    localparam int          DEF_DEPTH_BYTES = 256;
    localparam logic [31:0] DEF_HALT_WORD   = 32'hFFFF_FFFF;

    // Ceiling log2; elaboration-time helper for address/index widths.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Fetch-port and load-port signals between the IF stage / debug unit and the memory.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int IW     = 32
);
    // fetch side
    logic              i_step;
    logic [ADDR_W-1:0] i_addr;
    logic [IW-1:0]     o_data;
    logic              o_misaligned;
    // load side
    logic              i_load_start;
    logic [7:0]        i_byte;
    logic              i_byte_valid;
    logic              o_load_busy;
    logic              o_load_done;
    logic              o_overflow;
    logic [ADDR_W-1:0] o_word_count;

    modport master (
        output i_step, i_addr, i_load_start, i_byte, i_byte_valid,
        input  o_data, o_misaligned, o_load_busy, o_load_done, o_overflow, o_word_count
    );

    modport slave (
        input  i_step, i_addr, i_load_start, i_byte, i_byte_valid,
        output o_data, o_misaligned, o_load_busy, o_load_done, o_overflow, o_word_count
    );
endinterface

// File: rtl/byte_word_packer.sv
// Collects MSB-first bytes into a word; word_valid_o fires combinationally with the last byte.
module byte_word_packer
    import instr_mem_pkg::*;
#(
    parameter int WORD_BYTES = DEF_WORD_BYTES
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    clear_i,
    input  logic [7:0]              byte_i,
    input  logic                    byte_valid_i,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic                    word_valid_o
);
    localparam int IW    = 8 * WORD_BYTES;
    localparam int IDX_W = (clog2(WORD_BYTES) > 0) ? clog2(WORD_BYTES) : 1;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IW-9:0]    sh_q, sh_d;
    logic             last;

    assign last         = (idx_q == IDX_W'(WORD_BYTES - 1));
    assign word_o       = {sh_q, byte_i};
    assign word_valid_o = byte_valid_i && !clear_i && last;

    // Next slot index and shifted partial word; a clear drops any partial bytes.
    always_comb begin
        idx_d = idx_q;
        sh_d  = sh_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (byte_valid_i) begin
            idx_d = last ? '0 : idx_q + IDX_W'(1);
            sh_d  = word_o[IW-9:0];
        end
    end

    // Packer state advances on the falling edge like the rest of the memory.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            idx_q <= '0;
            sh_q  <= '0;
        end else begin
            idx_q <= idx_d;
            sh_q  <= sh_d;
        end
    end
endmodule

// File: rtl/instr_mem_loader.sv
// Big-endian byte-addressed instruction memory with a streaming program loader.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int                      WORD_BYTES  = DEF_WORD_BYTES,
    parameter int                      DEPTH_BYTES = DEF_DEPTH_BYTES,
    parameter logic [8*WORD_BYTES-1:0] HALT_WORD   = (8*WORD_BYTES)'(DEF_HALT_WORD)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    instr_mem_loader_if.slave  bus
);
    localparam int ADDR_W = clog2(DEPTH_BYTES);
    localparam int IW     = 8 * WORD_BYTES;
    localparam int OFF_W  = clog2(WORD_BYTES);

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_LOAD = 2'(ST_LOAD);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);

    logic [7:0]        mem [DEPTH_BYTES];
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [IW-1:0]     data_q;
    logic              mis_q;

    logic [IW-1:0]     pk_word;
    logic              pk_valid;
    logic [IW-1:0]     rd_word;
    logic              in_load;

    assign in_load = (state_q == S_LOAD);

    byte_word_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .clear_i      (bus.i_load_start),
        .byte_i       (bus.i_byte),
        .byte_valid_i (bus.i_byte_valid && in_load),
        .word_o       (pk_word),
        .word_valid_o (pk_valid)
    );

    // Loader FSM: start/restart clears progress; each packed word advances the pointer.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (bus.i_load_start) begin
            state_d  = S_LOAD;
            wr_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else if (in_load && pk_valid) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(WORD_BYTES);
            cnt_d    = cnt_q + ADDR_W'(1);
            if (pk_word == HALT_WORD) begin
                state_d = S_DONE;
            end else if (wr_ptr_q == ADDR_W'(DEPTH_BYTES - WORD_BYTES)) begin
                state_d = S_DONE;
                ovf_d   = 1'b1;
            end
        end
    end

    // Control registers update on the falling edge.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Memory write of a completed word, byte 0 (MSB) at the lowest address; not reset.
    always_ff @(negedge i_clk) begin
        if (!i_rst && in_load && pk_valid) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                mem[wr_ptr_q + ADDR_W'(b)] <= pk_word[IW-1-8*b -: 8];
            end
        end
    end

    // Big-endian word assembly at the fetch address (modulo memory size).
    always_comb begin
        rd_word = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            rd_word[IW-1-8*b -: 8] = mem[bus.i_addr + ADDR_W'(b)];
        end
    end

    // Fetch register: only outside LOAD; misaligned addresses return a NOP (zero).
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            data_q <= '0;
            mis_q  <= 1'b0;
        end else if (bus.i_step && !in_load) begin
            if (|bus.i_addr[OFF_W-1:0]) begin
                data_q <= '0;
                mis_q  <= 1'b1;
            end else begin
                data_q <= rd_word;
                mis_q  <= 1'b0;
            end
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_misaligned = mis_q;
    assign bus.o_load_busy  = in_load;
    assign bus.o_load_done  = (state_q == S_DONE);
    assign bus.o_overflow   = ovf_q;
    assign bus.o_word_count = cnt_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (256-byte and 16-byte instances).
module tb_instr_mem_loader;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    instr_mem_loader_if #(.ADDR_W(8), .IW(32)) bus   ();
    instr_mem_loader_if #(.ADDR_W(4), .IW(32)) bus16 ();

    instr_mem_loader #(.WORD_BYTES(4), .DEPTH_BYTES(256)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    instr_mem_loader #(.WORD_BYTES(4), .DEPTH_BYTES(16)) dut16 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the DUT acts on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        tick();
        bus.i_byte_valid = 1'b0;
    endtask

    task automatic send16(input logic [7:0] b);
        bus16.i_byte       = b;
        bus16.i_byte_valid = 1'b1;
        tick();
        bus16.i_byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a);
        bus.i_addr = a;
        bus.i_step = 1'b1;
        tick();
        bus.i_step = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.i_step = 0;   bus.i_addr = '0;   bus.i_load_start = 0;
        bus.i_byte = '0;  bus.i_byte_valid = 0;
        bus16.i_step = 0; bus16.i_addr = '0; bus16.i_load_start = 0;
        bus16.i_byte = '0; bus16.i_byte_valid = 0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_data", bus.o_data, 0);
        chk("rst_mis",  bus.o_misaligned, 0);
        chk("rst_busy", bus.o_load_busy, 0);
        chk("rst_done", bus.o_load_done, 0);
        chk("rst_ovf",  bus.o_overflow, 0);
        chk("rst_cnt",  bus.o_word_count, 0);

        // two words then HALT
        pulse_start();
        chk("t1_busy", bus.o_load_busy, 1);
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        chk("t1_cnt2", bus.o_word_count, 2);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        chk("t1_done", bus.o_load_done, 1);
        chk("t1_busy0", bus.o_load_busy, 0);
        chk("t1_cnt", bus.o_word_count, 3);
        chk("t1_ovf", bus.o_overflow, 0);
        fetch(8'h00);
        chk("t1_f00", bus.o_data, 32'h0011_2233);
        fetch(8'h04);
        chk("t1_f04", bus.o_data, 32'h4455_6677);
        fetch(8'h08);
        chk("t1_f08", bus.o_data, 32'hFFFF_FFFF);

        // misaligned fetch yields NOP, next aligned fetch clears the flag
        fetch(8'h05);
        chk("t2_mis_data", bus.o_data, 0);
        chk("t2_mis_flag", bus.o_misaligned, 1);
        fetch(8'h04);
        chk("t2_f04", bus.o_data, 32'h4455_6677);
        chk("t2_mis0", bus.o_misaligned, 0);

        // i_step=0 in DONE holds the fetch register
        bus.i_addr = 8'h00;
        tick();
        chk("t6_hold_done", bus.o_data, 32'h4455_6677);

        // restart mid-word; the byte offered with the restart pulse is dropped
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB);
        bus.i_byte = 8'hEE; bus.i_byte_valid = 1'b1; bus.i_load_start = 1'b1;
        tick();
        bus.i_byte_valid = 1'b0; bus.i_load_start = 1'b0;
        chk("t4_cnt_clr", bus.o_word_count, 0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("t4_cnt", bus.o_word_count, 1);
        chk("t4_busy", bus.o_load_busy, 1);

        // fetch attempt during LOAD is ignored
        fetch(8'h00);
        chk("t6_hold_load", bus.o_data, 32'h4455_6677);

        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        chk("t4_cnt2", bus.o_word_count, 2);
        fetch(8'h00);
        chk("t4_f00", bus.o_data, 32'h0102_0304);
        fetch(8'h04);
        chk("t4_f04", bus.o_data, 32'hFFFF_FFFF);

        // reset mid-load after 6 bytes
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        chk("t5_cnt_pre", bus.o_word_count, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_data", bus.o_data, 0);
        chk("t5_busy", bus.o_load_busy, 0);
        chk("t5_done", bus.o_load_done, 0);
        chk("t5_cnt",  bus.o_word_count, 0);
        chk("t5_ovf",  bus.o_overflow, 0);
        fetch(8'h00);
        chk("t5_f00", bus.o_data, 32'h1122_3344);
        fetch(8'h04);
        chk("t5_f04_partial_dropped", bus.o_data, 32'hFFFF_FFFF);

        // 16-byte memory fills without HALT -> overflow
        bus16.i_load_start = 1'b1;
        tick();
        bus16.i_load_start = 1'b0;
        for (int i = 1; i <= 15; i++) send16(8'(i));
        chk("t3_busy15", bus16.o_load_busy, 1);
        chk("t3_cnt15", bus16.o_word_count, 3);
        chk("t3_ovf15", bus16.o_overflow, 0);
        send16(8'h10);
        chk("t3_ovf", bus16.o_overflow, 1);
        chk("t3_done", bus16.o_load_done, 1);
        chk("t3_cnt", bus16.o_word_count, 4);
        bus16.i_addr = 4'hC; bus16.i_step = 1'b1;
        tick();
        bus16.i_step = 1'b0;
        chk("t3_f0c", bus16.o_data, 32'h0D0E_0F10);
        bus16.i_addr = 4'h0; bus16.i_step = 1'b1;
        tick();
        bus16.i_step = 1'b0;
        chk("t3_f00", bus16.o_data, 32'h0102_0304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
